// File: rtl/peripheral_io_bus.sv
// Memory-mapped peripheral block: switches, debounced buttons with edge latches, LED/HEX registers, 64-bit timer.
// Optional timer compare interrupt and CMP register enabled by defining TIMER_IRQ_EN.
module peripheral_io_bus #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [15:0] BASE_ADDR       = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [63:0] wdata,
  input  logic        write,
  output logic [63:0] rdata,
  input  logic [9:0]  sw,
  input  logic [2:0]  button,
  output logic [31:0] leds,
  output logic [15:0] hex_value,
  output logic        irq
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned NUM_SW  = 10;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [4:0] IDX_SW    = 5'd0;
  localparam logic [4:0] IDX_BTN   = 5'd1;
  localparam logic [4:0] IDX_EDGE  = 5'd2;
  localparam logic [4:0] IDX_LED   = 5'd3;
  localparam logic [4:0] IDX_HEX   = 5'd4;
  localparam logic [4:0] IDX_TIMER = 5'd5;
`ifdef TIMER_IRQ_EN
  localparam logic [4:0] IDX_CMP   = 5'd6;
`endif

  logic [NUM_SW-1:0]  sw_meta;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] btn_meta;
  logic [NUM_BTN-1:0] btn_sync;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] edge_latch;
  logic [CNT_W-1:0]   db_cnt [NUM_BTN];
  logic [63:0]        timer;

  logic               sel_c;
  logic [4:0]         idx_c;
  logic               wr_c;
  logic               wr_edge_c;
  logic               wr_led_c;
  logic               wr_hex_c;
  logic               wr_timer_c;
  logic [NUM_BTN-1:0] rise_c;
  logic [NUM_BTN-1:0] w1c_c;
  logic [63:0]        rd_c;

`ifdef TIMER_IRQ_EN
  logic [63:0] cmp;
  logic        wr_cmp_c;
`endif

  // Address decode: 256-byte window, 8-byte aligned registers
  always_comb begin
    sel_c      = (address[15:8] == BASE_ADDR[15:8]) && (address[2:0] == 3'b000);
    idx_c      = address[7:3];
    wr_c       = write && sel_c;
    wr_edge_c  = wr_c && (idx_c == IDX_EDGE);
    wr_led_c   = wr_c && (idx_c == IDX_LED);
    wr_hex_c   = wr_c && (idx_c == IDX_HEX);
    wr_timer_c = wr_c && (idx_c == IDX_TIMER);
`ifdef TIMER_IRQ_EN
    wr_cmp_c   = wr_c && (idx_c == IDX_CMP);
`endif
    w1c_c      = wr_edge_c ? wdata[NUM_BTN-1:0] : '0;
  end

  // A button's accepted level rises when its saturated counter releases a 1
  always_comb begin
    rise_c = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rise_c[i] = btn_sync[i] && !btn_level[i] && (db_cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    rd_c = '0;
    if (sel_c) begin
      case (idx_c)
        IDX_SW:    rd_c = 64'(sw_sync);
        IDX_BTN:   rd_c = 64'(btn_level);
        IDX_EDGE:  rd_c = 64'(edge_latch);
        IDX_LED:   rd_c = 64'(leds);
        IDX_HEX:   rd_c = 64'(hex_value);
        IDX_TIMER: rd_c = timer;
`ifdef TIMER_IRQ_EN
        IDX_CMP:   rd_c = cmp;
`endif
        default:   rd_c = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata      <= '0;
      leds       <= '0;
      hex_value  <= '0;
      edge_latch <= '0;
      timer      <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      btn_meta   <= '0;
      btn_sync   <= '0;
      btn_level  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      rdata    <= rd_c;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= button;
      btn_sync <= btn_meta;
      // Counter holds at its maximum until the accepted level catches up
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          btn_level[i] <= btn_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
      edge_latch <= (edge_latch & ~w1c_c) | rise_c;
      if (wr_led_c) leds <= wdata[31:0];
      if (wr_hex_c) hex_value <= wdata[15:0];
      timer <= wr_timer_c ? wdata : timer + 64'd1;
    end
  end

`ifdef TIMER_IRQ_EN
  // Compare interrupt: sticky until CMP or TIMER is written; clear beats set
  always_ff @(posedge clock) begin
    if (!reset) begin
      cmp <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_cmp_c) cmp <= wdata;
      if (wr_cmp_c || wr_timer_c) begin
        irq <= 1'b0;
      end else if ((timer == cmp) && (cmp != '0)) begin
        irq <= 1'b1;
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
